glitch_sequencer: RTL and testbench

Multi-pulse, parametrised successor to the single-pulse power-dip glitcher. After a selected trigger edge it emits a programmable train of up to NUM_PULSES output pulses. Each pulse has its own delay and width, counted in fast-clock cycles. The block runs entirely in the fast PLL clock domain; the register front-end delivers data-valid strobes already synchronous to i_Clk.

---
 rtl/glitch_pkg.sv | 39 +++
 rtl/trigger_sync_edge.sv | 45 ++++
 rtl/glitch_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_glitch_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_pkg.sv
// Shared encodings for the glitch sequencer: FSM states, control-byte fields,
// trigger edge modes and status-word layout.
package glitch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2,
    ST_PULSE = 2'd3
  } state_t;

  // Control byte fields
  localparam int CTRL_ARM     = 0;
  localparam int CTRL_EDGE_LO = 1;
  localparam int CTRL_EDGE_HI = 2;
  localparam int CTRL_REARM   = 3;

  // Edge-mode codes; any code with bit 1 set selects both edges
  localparam logic [1:0] EDGE_FALL = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;

  // Status word layout
  localparam int STAT_ARMED   = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_DONE    = 2;
  localparam int STAT_CFG_ERR = 3;
  localparam int STAT_SLOT_LO = 4;
  localparam int STAT_SLOT_HI = 7;
  localparam int STAT_FIRE_LO = 16;
  localparam int STAT_FIRE_HI = 31;

  localparam logic [15:0] FIRE_MAX = 16'hFFFF;

  function automatic logic is_busy(input state_t s);
    return (s == ST_DELAY) || (s == ST_PULSE);
  endfunction

endpackage

// File: rtl/trigger_sync_edge.sv
// Brings the asynchronous trigger into the fast clock domain and produces a
// one-cycle strobe for the selected edge polarity.
module trigger_sync_edge
  import glitch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic [1:0] edge_mode,
  output logic       edge_strobe
);

  logic sync_q1;
  logic sync_q2;
  logic prev_q;
  logic rise;
  logic fall;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q1 <= trigger;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
    end
  end

  always_comb begin
    rise = sync_q2 & ~prev_q;
    fall = ~sync_q2 & prev_q;
    if (edge_mode[1]) begin
      edge_strobe = rise | fall;
    end else if (edge_mode == EDGE_RISE) begin
      edge_strobe = rise;
    end else begin
      edge_strobe = fall;
    end
  end

endmodule

// File: rtl/glitch_sequencer.sv
// Multi-pulse glitch sequencer: after a selected trigger edge it plays a table
// of delay/width pairs onto o_glitch_out, counted in fast-clock cycles.
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int NUM_PULSES = 4,
  parameter int IDX_W      = (NUM_PULSES > 1) ? $clog2(NUM_PULSES) : 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_trigger,
  input  logic             i_cfg_DV,
  input  logic [IDX_W-1:0] i_cfg_idx,
  input  logic [CNT_W-1:0] i_cfg_delay,
  input  logic [CNT_W-1:0] i_cfg_width,
  input  logic             i_ctrl_DV,
  input  logic [7:0]       i_ctrl,
  input  logic [IDX_W:0]   i_pulse_count,
  output logic             o_glitch_out,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_status
);

  localparam logic [IDX_W:0] MAX_COUNT = (IDX_W + 1)'(NUM_PULSES);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [IDX_W-1:0] idx_inc;

  logic [1:0]       edge_mode_q;
  logic             rearm_q;
  logic [IDX_W:0]   pulse_cnt_q;
  logic [IDX_W:0]   pulse_cnt_clamped;
  logic             done_sticky_q;
  logic             cfg_err_q;
  logic [15:0]      fire_q;
  logic             glitch_q;
  logic             done_q;
  logic [31:0]      status_q;
  logic [31:0]      status_d;

  logic [CNT_W-1:0] delay_tab [NUM_PULSES];
  logic [CNT_W-1:0] width_tab [NUM_PULSES];

  logic             edge_strobe;
  logic             ctrl_arm;
  logic             cfg_ok;
  logic             last_slot;
  logic             train_end;
  logic [CNT_W-1:0] slot_width;
  logic [CNT_W-1:0] width_eff;
  logic             ctrl_unused;

  trigger_sync_edge u_trig (
    .clk         (i_Clk),
    .rst         (i_Rst),
    .trigger     (i_trigger),
    .edge_mode   (edge_mode_q),
    .edge_strobe (edge_strobe)
  );

  assign ctrl_unused = ^i_ctrl[7:4];
  assign ctrl_arm    = i_ctrl_DV & i_ctrl[CTRL_ARM];
  assign idx_inc     = idx_q + 1'b1;
  assign last_slot   = ({1'b0, idx_q} + 1'b1) >= pulse_cnt_q;
  assign slot_width  = width_tab[idx_q];
  assign width_eff   = (slot_width == '0) ? CNT_W'(1) : slot_width;
  assign cfg_ok      = ((state_q == ST_IDLE) || (state_q == ST_ARMED)) &&
                       ({1'b0, i_cfg_idx} < MAX_COUNT);

  always_comb begin
    if (i_pulse_count == '0) begin
      pulse_cnt_clamped = (IDX_W + 1)'(1);
    end else if (i_pulse_count > MAX_COUNT) begin
      pulse_cnt_clamped = MAX_COUNT;
    end else begin
      pulse_cnt_clamped = i_pulse_count;
    end
  end

  // Next-state logic. A control write overrides everything, including a
  // trigger edge arriving in the same cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no branch
    // leaves it unassigned and infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    train_end = 1'b0;

    if (i_ctrl_DV) begin
      state_d = i_ctrl[CTRL_ARM] ? ST_ARMED : ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_ARMED: begin
          if (edge_strobe) begin
            state_d = ST_DELAY;
            idx_d   = '0;
            cnt_d   = delay_tab[0];
          end
        end
        ST_DELAY: begin
          if (cnt_q == '0) begin
            state_d = ST_PULSE;
            cnt_d   = width_eff;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_q == CNT_W'(1)) begin
            if (last_slot) begin
              train_end = 1'b1;
              state_d   = rearm_q ? ST_ARMED : ST_IDLE;
              cnt_d     = '0;
            end else begin
              state_d = ST_DELAY;
              idx_d   = idx_inc;
              cnt_d   = delay_tab[idx_inc];
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      edge_mode_q   <= EDGE_FALL;
      rearm_q       <= 1'b0;
      pulse_cnt_q   <= (IDX_W + 1)'(1);
      done_sticky_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      fire_q        <= '0;
      glitch_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      glitch_q <= (state_d == ST_PULSE);
      done_q   <= train_end;

      if (ctrl_arm) begin
        edge_mode_q   <= i_ctrl[CTRL_EDGE_HI:CTRL_EDGE_LO];
        rearm_q       <= i_ctrl[CTRL_REARM];
        pulse_cnt_q   <= pulse_cnt_clamped;
        done_sticky_q <= 1'b0;
      end else if (train_end) begin
        done_sticky_q <= 1'b1;
        if (fire_q != FIRE_MAX) begin
          fire_q <= fire_q + 16'd1;
        end
      end

      if (i_cfg_DV && !cfg_ok) begin
        cfg_err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      // NOTE: the table is small flop storage, so it is cleared on reset and a
      // fresh arm can never replay timing left over from before the reset.
      for (int i = 0; i < NUM_PULSES; i++) begin
        delay_tab[i] <= '0;
        width_tab[i] <= '0;
      end
    end else if (i_cfg_DV && cfg_ok) begin
      delay_tab[i_cfg_idx] <= i_cfg_delay;
      width_tab[i_cfg_idx] <= i_cfg_width;
    end
  end

  // Status is a registered snapshot, one cycle behind the live state.
  always_comb begin
    status_d                             = '0;
    status_d[STAT_ARMED]                 = (state_q == ST_ARMED);
    status_d[STAT_BUSY]                  = is_busy(state_q);
    status_d[STAT_DONE]                  = done_sticky_q;
    status_d[STAT_CFG_ERR]               = cfg_err_q;
    status_d[STAT_SLOT_HI:STAT_SLOT_LO]  = 4'(idx_q);
    status_d[STAT_FIRE_HI:STAT_FIRE_LO]  = fire_q;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign o_glitch_out = glitch_q;
  assign o_busy       = is_busy(state_q);
  assign o_done       = done_q;
  assign o_status     = status_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: per-scenario tasks compare captured
// waveforms (bit k = value just after clock edge k) against hand-derived masks.
module tb_glitch_sequencer;

  localparam int CNT_W      = 32;
  localparam int NUM_PULSES = 4;
  localparam int IDX_W      = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             trigger;
  logic             cfg_dv;
  logic [IDX_W-1:0] cfg_idx;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_width;
  logic             ctrl_dv;
  logic [7:0]       ctrl;
  logic [IDX_W:0]   pulse_count;
  logic             glitch_out;
  logic             busy;
  logic             done;
  logic [31:0]      status;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] out_vec;
  logic [31:0] done_vec;
  logic [31:0] busy_vec;
  logic [31:0] sbusy_vec;

  glitch_sequencer #(
    .CNT_W      (CNT_W),
    .NUM_PULSES (NUM_PULSES),
    .IDX_W      (IDX_W)
  ) dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_trigger     (trigger),
    .i_cfg_DV      (cfg_dv),
    .i_cfg_idx     (cfg_idx),
    .i_cfg_delay   (cfg_delay),
    .i_cfg_width   (cfg_width),
    .i_ctrl_DV     (ctrl_dv),
    .i_ctrl        (ctrl),
    .i_pulse_count (pulse_count),
    .o_glitch_out  (glitch_out),
    .o_busy        (busy),
    .o_done        (done),
    .o_status      (status)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst         = 1'b1;
    trigger     = 1'b0;
    cfg_dv      = 1'b0;
    cfg_idx     = '0;
    cfg_delay   = '0;
    cfg_width   = '0;
    ctrl_dv     = 1'b0;
    ctrl        = '0;
    pulse_count = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic cfg_write(input logic [IDX_W-1:0] idx, input int d, input int w);
    cfg_dv    = 1'b1;
    cfg_idx   = idx;
    cfg_delay = CNT_W'(d);
    cfg_width = CNT_W'(w);
    tick();
    cfg_dv = 1'b0;
  endtask

  task automatic arm(input logic [7:0] c, input logic [IDX_W:0] n);
    ctrl_dv     = 1'b1;
    ctrl        = c;
    pulse_count = n;
    tick();
    ctrl_dv = 1'b0;
  endtask

  task automatic capture(input int n);
    out_vec   = '0;
    done_vec  = '0;
    busy_vec  = '0;
    sbusy_vec = '0;
    for (int k = 1; k <= n; k++) begin
      tick();
      out_vec[k]   = glitch_out;
      done_vec[k]  = done;
      busy_vec[k]  = busy;
      sbusy_vec[k] = status[1];
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++;
    if ({glitch_out, busy, done} !== 3'b000)
      $display("FAIL reset_outputs got %b want 000", {glitch_out, busy, done});
    else pass_cnt++;
    total_cnt++;
    if (status !== 32'h0) $display("FAIL reset_status got %h want 00000000", status);
    else pass_cnt++;
  endtask

  task automatic test_single_pulse();
    apply_reset();
    cfg_write(0, 5, 3);
    arm(8'h03, 3'd1);
    trigger = 1'b1;
    capture(16);
    total_cnt++;
    if (out_vec !== 32'h0000_0E00) $display("FAIL single_out got %h want 00000e00", out_vec);
    else pass_cnt++;
    total_cnt++;
    if (done_vec !== 32'h0000_1000) $display("FAIL single_done got %h want 00001000", done_vec);
    else pass_cnt++;
    total_cnt++;
    if (busy_vec !== 32'h0000_0FF8) $display("FAIL single_busy got %h want 00000ff8", busy_vec);
    else pass_cnt++;
    total_cnt++;
    if (sbusy_vec !== 32'h0000_1FF0) $display("FAIL single_status_busy got %h want 00001ff0", sbusy_vec);
    else pass_cnt++;
    total_cnt++;
    if (status[31:16] !== 16'd1) $display("FAIL single_fire got %0d want 1", status[31:16]);
    else pass_cnt++;
    total_cnt++;
    if ({status[2], status[0], busy} !== 3'b100)
      $display("FAIL single_idle_flags got %b want 100", {status[2], status[0], busy});
    else pass_cnt++;
  endtask

  task automatic test_multi_pulse();
    apply_reset();
    cfg_write(0, 2, 1);
    cfg_write(1, 0, 4);
    cfg_write(2, 7, 0);
    arm(8'h03, 3'd3);
    trigger = 1'b1;
    capture(24);
    total_cnt++;
    if (out_vec !== 32'h0010_0F40) $display("FAIL multi_out got %h want 00100f40", out_vec);
    else pass_cnt++;
    total_cnt++;
    if (done_vec !== 32'h0020_0000) $display("FAIL multi_done got %h want 00200000", done_vec);
    else pass_cnt++;
    total_cnt++;
    if ({status[31:16], status[3]} !== {16'd1, 1'b0})
      $display("FAIL multi_status got fire=%0d err=%b want fire=1 err=0", status[31:16], status[3]);
    else pass_cnt++;
  endtask

  task automatic test_auto_rearm();
    apply_reset();
    cfg_write(0, 2, 1);
    arm(8'h0D, 3'd1);
    trigger = 1'b1;
    capture(15);
    total_cnt++;
    if ({out_vec, done_vec} !== {32'h40, 32'h80})
      $display("FAIL rearm_train1 got out=%h done=%h want out=00000040 done=00000080", out_vec, done_vec);
    else pass_cnt++;
    trigger = 1'b0;
    capture(15);
    total_cnt++;
    if ({out_vec, done_vec} !== {32'h40, 32'h80})
      $display("FAIL rearm_train2 got out=%h done=%h want out=00000040 done=00000080", out_vec, done_vec);
    else pass_cnt++;
    total_cnt++;
    if ({status[31:16], status[0], busy} !== {16'd2, 1'b1, 1'b0})
      $display("FAIL rearm_status got fire=%0d armed=%b busy=%b want fire=2 armed=1 busy=0",
               status[31:16], status[0], busy);
    else pass_cnt++;
  endtask

  task automatic test_pulse_count();
    apply_reset();
    for (int s = 0; s < NUM_PULSES; s++) cfg_write(IDX_W'(s), 0, 1);
    arm(8'h03, 3'd7);
    trigger = 1'b1;
    capture(14);
    total_cnt++;
    if ({out_vec, done_vec} !== {32'h550, 32'h800})
      $display("FAIL count_clamp got out=%h done=%h want out=00000550 done=00000800", out_vec, done_vec);
    else pass_cnt++;
    trigger = 1'b0;
    tick();
    tick();
    tick();
    arm(8'h03, 3'd0);
    trigger = 1'b1;
    capture(8);
    total_cnt++;
    if ({out_vec, done_vec} !== {32'h10, 32'h20})
      $display("FAIL count_zero got out=%h done=%h want out=00000010 done=00000020", out_vec, done_vec);
    else pass_cnt++;
  endtask

  task automatic test_abort_and_cfg_err();
    apply_reset();
    cfg_write(0, 1, 10);
    arm(8'h03, 3'd1);
    trigger = 1'b1;
    capture(7);
    total_cnt++;
    if (out_vec !== 32'hE0) $display("FAIL abort_prefix got %h want 000000e0", out_vec);
    else pass_cnt++;
    ctrl_dv = 1'b1;
    ctrl    = 8'h00;
    tick();
    ctrl_dv = 1'b0;
    total_cnt++;
    if ({glitch_out, busy} !== 2'b00) $display("FAIL abort_edge got out/busy=%b want 00", {glitch_out, busy});
    else pass_cnt++;
    capture(6);
    total_cnt++;
    if ({out_vec, done_vec} !== 64'h0) $display("FAIL abort_quiet got out=%h done=%h want 0", out_vec, done_vec);
    else pass_cnt++;
    total_cnt++;
    if ({status[31:16], status[2], status[0]} !== 18'h0)
      $display("FAIL abort_status got fire=%0d done=%b armed=%b want 0", status[31:16], status[2], status[0]);
    else pass_cnt++;

    trigger = 1'b0;
    tick();
    cfg_write(0, 20, 2);
    tick();
    tick();
    total_cnt++;
    if (status[3] !== 1'b0) $display("FAIL cfg_idle_no_err got %b want 0", status[3]);
    else pass_cnt++;
    arm(8'h03, 3'd1);
    trigger  = 1'b1;
    out_vec  = '0;
    done_vec = '0;
    busy_vec = '0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) begin
        cfg_dv    = 1'b1;
        cfg_idx   = '0;
        cfg_delay = 32'd3;
        cfg_width = 32'd7;
      end else begin
        cfg_dv = 1'b0;
      end
      tick();
      out_vec[k]  = glitch_out;
      done_vec[k] = done;
      busy_vec[k] = busy;
    end
    total_cnt++;
    if (busy_vec[4] !== 1'b1) $display("FAIL cfg_busy_window got %b want 1", busy_vec[4]);
    else pass_cnt++;
    total_cnt++;
    if ({out_vec, done_vec} !== {32'h0300_0000, 32'h0400_0000})
      $display("FAIL cfg_dropped got out=%h done=%h want out=03000000 done=04000000", out_vec, done_vec);
    else pass_cnt++;
    total_cnt++;
    if ({status[3], status[31:16]} !== {1'b1, 16'd1})
      $display("FAIL cfg_err_sticky got err=%b fire=%0d want err=1 fire=1", status[3], status[31:16]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_pulse();
    apply_reset();
    cfg_write(0, 0, 20);
    arm(8'h03, 3'd1);
    trigger = 1'b1;
    capture(6);
    total_cnt++;
    if (out_vec !== 32'h70) $display("FAIL midrst_prefix got %h want 00000070", out_vec);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({glitch_out, busy, done, status} !== 35'h0)
      $display("FAIL midrst_async got out=%b busy=%b done=%b status=%h want all 0",
               glitch_out, busy, done, status);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    out_vec  = '0;
    busy_vec = '0;
    for (int k = 1; k <= 20; k++) begin
      trigger = (k % 4) < 2;
      tick();
      out_vec[k]  = glitch_out;
      busy_vec[k] = busy;
    end
    total_cnt++;
    if ({out_vec, busy_vec} !== 64'h0)
      $display("FAIL idle_edges got out=%h busy=%h want 0", out_vec, busy_vec);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_pulse();
    test_multi_pulse();
    test_auto_rearm();
    test_pulse_count();
    test_abort_and_cfg_err();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
